// File: rtl/ddr_memtest_if.sv
// Wishbone bus between the memory test engine (master) and the DDR controller port (slave).
interface ddr_memtest_if;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      input  wb_dat_i, wb_ack_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
      output wb_dat_i, wb_ack_i
   );
endinterface

// File: rtl/ddr_memtest.sv
// Memory test engine: LFSR fill of a word range, then read-back compare with error reporting.
// Optional ack timeout is enabled by defining MEMTEST_TIMEOUT_EN.
module ddr_memtest #(
   parameter logic [31:0] base_adr       = 32'h0000_0000,
   parameter int          mem_words      = 1024,
   parameter logic [31:0] seed           = 32'hACE1_2345,
   parameter int          timeout_cycles = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic [15:0]         err_count,
   output logic [31:0]         first_err_adr,
   ddr_memtest_if.master       wb
);

   localparam int IW = $clog2(mem_words) + 1;
   localparam logic [IW-1:0] MEM_WORDS_W = IW'(mem_words);

   typedef enum logic [2:0] {
      IDLE, W_REQ, W_IDLE, R_REQ, R_IDLE, DONE
   } state_t;

   state_t          state_reg;
   logic [31:0]     lfsr_reg;
   logic [IW-1:0]   idx_reg;
   logic [31:0]     lfsr_next;
   logic [31:0]     idx_adr;

   assign lfsr_next = {lfsr_reg[30:0], lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0]};
   assign idx_adr   = base_adr + (32'(idx_reg) << 2);

`ifdef MEMTEST_TIMEOUT_EN
   localparam int TW = $clog2(timeout_cycles + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(timeout_cycles - 1);
   logic [TW-1:0] tmo_cnt_reg;
   logic          timeout_reg;
   assign timeout = timeout_reg;
`else
   localparam int unused_timeout_cycles = timeout_cycles;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         lfsr_reg      <= '0;
         idx_reg       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_count     <= '0;
         first_err_adr <= '0;
         wb.wb_cyc_o   <= 1'b0;
         wb.wb_stb_o   <= 1'b0;
         wb.wb_we_o    <= 1'b0;
         wb.wb_adr_o   <= '0;
         wb.wb_dat_o   <= '0;
         wb.wb_sel_o   <= '0;
`ifdef MEMTEST_TIMEOUT_EN
         tmo_cnt_reg   <= '0;
         timeout_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  pass          <= 1'b0;
                  err_count     <= '0;
                  first_err_adr <= '0;
                  idx_reg       <= '0;
                  lfsr_reg      <= seed;
                  wb.wb_cyc_o   <= 1'b1;
                  wb.wb_stb_o   <= 1'b1;
                  wb.wb_we_o    <= 1'b1;
                  wb.wb_adr_o   <= base_adr;
                  wb.wb_dat_o   <= seed;
                  wb.wb_sel_o   <= 4'hF;
`ifdef MEMTEST_TIMEOUT_EN
                  tmo_cnt_reg   <= '0;
                  timeout_reg   <= 1'b0;
`endif
                  state_reg     <= W_REQ;
               end
            end

            // Both request phases share the ack handling; only reads compare.
            W_REQ, R_REQ: begin
               if (wb.wb_ack_i) begin
                  if (!wb.wb_we_o && (wb.wb_dat_i != lfsr_reg)) begin
                     if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                     if (err_count == 16'd0)
                        first_err_adr <= wb.wb_adr_o;
                  end
                  lfsr_reg    <= lfsr_next;
                  idx_reg     <= idx_reg + IW'(1);
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_sel_o <= 4'h0;
                  state_reg   <= (state_reg == W_REQ) ? W_IDLE : R_IDLE;
               end
`ifdef MEMTEST_TIMEOUT_EN
               else if (tmo_cnt_reg == TMO_LAST) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  wb.wb_we_o  <= 1'b0;
                  wb.wb_sel_o <= 4'h0;
                  timeout_reg <= 1'b1;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  pass        <= 1'b0;
                  state_reg   <= DONE;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
               end
`endif
            end

            W_IDLE: begin
               wb.wb_stb_o <= 1'b1;
               wb.wb_sel_o <= 4'hF;
`ifdef MEMTEST_TIMEOUT_EN
               tmo_cnt_reg <= '0;
`endif
               if (idx_reg < MEM_WORDS_W) begin
                  wb.wb_adr_o <= idx_adr;
                  wb.wb_dat_o <= lfsr_reg;
                  state_reg   <= W_REQ;
               end else begin
                  lfsr_reg    <= seed;
                  idx_reg     <= '0;
                  wb.wb_we_o  <= 1'b0;
                  wb.wb_adr_o <= base_adr;
                  wb.wb_dat_o <= seed;
                  state_reg   <= R_REQ;
               end
            end

            R_IDLE: begin
               if (idx_reg < MEM_WORDS_W) begin
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_sel_o <= 4'hF;
                  wb.wb_adr_o <= idx_adr;
                  wb.wb_dat_o <= lfsr_reg;
`ifdef MEMTEST_TIMEOUT_EN
                  tmo_cnt_reg <= '0;
`endif
                  state_reg   <= R_REQ;
               end else begin
                  wb.wb_cyc_o <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
`ifdef MEMTEST_TIMEOUT_EN
                  pass        <= (err_count == 16'd0) && !timeout_reg;
`else
                  pass        <= (err_count == 16'd0);
`endif
                  state_reg   <= DONE;
               end
            end

            // Status outputs stay registered; done remains set back in IDLE.
            DONE: state_reg <= IDLE;

            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_memtest.sv
// Bench for ddr_memtest: behavioural Wishbone slave memory plus a pattern/error reference model.
module tb_ddr_memtest;

   localparam int          WORDS = 16;
   localparam logic [31:0] SEED  = 32'hACE1_2345;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, pass, timeout;
   logic [15:0] err_count;
   logic [31:0] first_err_adr;

   ddr_memtest_if bus ();

   ddr_memtest #(
      .base_adr(32'h0000_0000),
      .mem_words(WORDS),
      .seed(SEED),
      .timeout_cycles(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .busy(busy),
      .done(done),
      .pass(pass),
      .timeout(timeout),
      .err_count(err_count),
      .first_err_adr(first_err_adr),
      .wb(bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // slave configuration, set by the stimulus sequence
   int corrupt_idx = -1;
   bit zero_rd = 1'b0;
   bit rand_lat = 1'b0;
   bit no_ack = 1'b0;

   logic [31:0] mem [WORDS];
   logic        s_ack = 1'b0;
   logic [31:0] s_dat = '0;
   int          wait_cnt = 0;
   int          lat = 0;
   int          nrd = 0;
   logic [63:0] wr_log [$];
   int          stable_viol = 0;

   assign bus.wb_ack_i = s_ack;
   assign bus.wb_dat_i = s_dat;

   always @(posedge clk) begin
      if (reset) begin
         s_ack    <= 1'b0;
         wait_cnt <= 0;
      end else if (bus.wb_cyc_o && bus.wb_stb_o && !s_ack && !no_ack) begin
         if (wait_cnt >= lat) begin
            s_ack    <= 1'b1;
            wait_cnt <= 0;
            lat      <= rand_lat ? int'($urandom_range(0, 7)) : 0;
            if (bus.wb_we_o) begin
               mem[bus.wb_adr_o[5:2]] <= bus.wb_dat_o;
               wr_log.push_back({bus.wb_adr_o, bus.wb_dat_o});
               $display("xfer WR adr=%h dat=%h", bus.wb_adr_o, bus.wb_dat_o);
            end else begin
               s_dat <= zero_rd ? 32'h0 :
                        (mem[bus.wb_adr_o[5:2]] ^ ((int'(bus.wb_adr_o[5:2]) == corrupt_idx) ? 32'h1 : 32'h0));
               nrd   <= nrd + 1;
               $display("xfer RD adr=%h", bus.wb_adr_o);
            end
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         s_ack <= 1'b0;
      end
   end

   // A stalled request must hold address, data and direction.
   logic        p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
   logic [31:0] p_adr = '0, p_dat = '0;
   always @(negedge clk) begin
      if (p_stb && !p_ack && bus.wb_stb_o &&
          (bus.wb_adr_o !== p_adr || bus.wb_dat_o !== p_dat || bus.wb_we_o !== p_we))
         stable_viol <= stable_viol + 1;
      p_stb <= bus.wb_stb_o;
      p_ack <= bus.wb_ack_i;
      p_adr <= bus.wb_adr_o;
      p_dat <= bus.wb_dat_o;
      p_we  <= bus.wb_we_o;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [31:0] l = SEED;
      repeat (i) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
      return l;
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 3000 && !done; n++) @(negedge clk);
      check("done_reached", {31'd0, done}, 32'd1);
   endtask

   task automatic wait_wr_adr(input logic [31:0] a);
      for (int n = 0; n < 500 && !(bus.wb_stb_o && bus.wb_we_o && bus.wb_adr_o == a); n++)
         @(negedge clk);
      check("reach_wr_adr", bus.wb_adr_o, a);
   endtask

   // One full test run, checked against the pattern and the slave's configured faults.
   task automatic run_and_check(input string tag);
      int base_w = wr_log.size();
      int base_r = nrd;
      int n_err = 0;
      int first = -1;
      logic [31:0] ret;
      pulse_start();
      check({tag, "_first_cyc"}, {31'd0, bus.wb_cyc_o}, 32'd1);
      check({tag, "_first_we"},  {31'd0, bus.wb_we_o}, 32'd1);
      check({tag, "_first_adr"}, bus.wb_adr_o, 32'h0);
      check({tag, "_first_dat"}, bus.wb_dat_o, SEED);
      check({tag, "_first_sel"}, {28'd0, bus.wb_sel_o}, 32'hF);
      check({tag, "_busy"},      {31'd0, busy}, 32'd1);
      check({tag, "_clr_done"},  {31'd0, done}, 32'd0);
      check({tag, "_clr_err"},   {16'd0, err_count}, 32'd0);
      check({tag, "_clr_fadr"},  first_err_adr, 32'd0);
      wait_done();
      check({tag, "_n_writes"}, wr_log.size() - base_w, WORDS);
      check({tag, "_n_reads"},  nrd - base_r, WORDS);
      for (int i = 0; i < WORDS; i++) begin
         if (base_w + i < wr_log.size()) begin
            check({tag, "_wr_adr"}, wr_log[base_w + i][63:32], 32'(i * 4));
            check({tag, "_wr_dat"}, wr_log[base_w + i][31:0], pat(i));
         end
         ret = zero_rd ? 32'h0 : (pat(i) ^ ((i == corrupt_idx) ? 32'h1 : 32'h0));
         if (ret != pat(i)) begin
            n_err++;
            if (first < 0) first = i;
         end
      end
      check({tag, "_busy_end"},  {31'd0, busy}, 32'd0);
      check({tag, "_err_count"}, {16'd0, err_count}, 32'(n_err));
      check({tag, "_first_err"}, first_err_adr, (first < 0) ? 32'd0 : 32'(first * 4));
      check({tag, "_pass"},      {31'd0, pass}, (n_err == 0) ? 32'd1 : 32'd0);
      check({tag, "_cyc_end"},   {31'd0, bus.wb_cyc_o}, 32'd0);
      $display("run %s: errors=%0d first=%0d pass=%0b", tag, err_count, first, pass);
   endtask

   initial begin
      int base_w;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_timeout", {31'd0, timeout}, 32'd0);
      check("rst_err", {16'd0, err_count}, 32'd0);
      check("rst_fadr", first_err_adr, 32'd0);
      check("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      check("rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
      check("rst_sel", {28'd0, bus.wb_sel_o}, 32'd0);
      reset = 1'b0;

      run_and_check("clean");

      corrupt_idx = 5;
      run_and_check("bitflip5");
      corrupt_idx = -1;

      zero_rd = 1'b1;
      run_and_check("zeros");
      zero_rd = 1'b0;
      run_and_check("clean_rerun");

      // start during write 3 is ignored
      base_w = wr_log.size();
      pulse_start();
      wait_wr_adr(32'hC);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done();
      check("ign_start_writes", wr_log.size() - base_w, WORDS);
      check("ign_start_pass", {31'd0, pass}, 32'd1);

      // reset during write 7 aborts immediately
      pulse_start();
      wait_wr_adr(32'h1C);
      reset = 1'b1;
      @(negedge clk);
      check("abort_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      check("abort_stb", {31'd0, bus.wb_stb_o}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_idle_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      run_and_check("after_abort");

      // random ack latency
      rand_lat = 1'b1;
      for (int r = 0; r < 4; r++) run_and_check($sformatf("randlat%0d", r));
      rand_lat = 1'b0;
      check("stall_stable", stable_viol, 0);

      // slave that never acks
      no_ack = 1'b1;
      pulse_start();
      check("noack_stb", {31'd0, bus.wb_stb_o}, 32'd1);
`ifdef MEMTEST_TIMEOUT_EN
      begin
         int dropped = 0;
         repeat (63) begin
            @(negedge clk);
            if (!bus.wb_cyc_o) dropped++;
         end
         check("tmo_early_drop", dropped, 0);
      end
      @(negedge clk);
      check("tmo_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
      check("tmo_flag", {31'd0, timeout}, 32'd1);
      check("tmo_done", {31'd0, done}, 32'd1);
      check("tmo_pass", {31'd0, pass}, 32'd0);
      check("tmo_busy", {31'd0, busy}, 32'd0);
`else
      repeat (200) @(negedge clk);
      check("noack_busy", {31'd0, busy}, 32'd1);
      check("noack_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
      check("noack_timeout", {31'd0, timeout}, 32'd0);
      check("noack_done", {31'd0, done}, 32'd0);
`endif
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      no_ack = 1'b0;
      run_and_check("final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
